mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store sequencer between the EX/MEM pipeline register and the word-addressed data memory.
//  Converts byte-addressed RV32I loads/stores into word memory cycles: read-modify-write for sb/sh,
//  split access for misaligned requests spanning two words, load sign/zero extension, range check.
//  Holds the pipeline (req_ready low) while a request is in flight.
// PARAMETERS
//  MEM_WORDS  70  number of 32-bit words in data memory; valid word index 0..MEM_WORDS-1
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  req_valid   in   1   request present; fields held stable until accepted
//  req_ready   out  1   high only in IDLE with rst low; accept = req_valid & req_ready at rising edge
//  req_store   in   1   1 = store, 0 = load
//  req_funct3  in   3   RV32I funct3 (lb/lh/lw/lbu/lhu, sb/sh/sw)
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data (low byte/half used for sb/sh)
//  resp_valid  out  1   one-cycle pulse, request complete
//  resp_err    out  1   valid with resp_valid; illegal funct3 or address out of range
//  load_data   out  32  extended load result; valid with resp_valid, 0 for stores/errors
//  mem_addr    out  32  word index to memory
//  mem_re      out  1   memory read enable
//  mem_we      out  1   memory write enable (write commits at rising edge)
//  mem_funct3  out  3   constant 3'b010 (full-word writes only)
//  mem_wdata   out  32  merged write word
//  mem_rdata   in   32  memory read data, combinational from mem_addr/mem_re
// BEHAVIOUR
//  States: IDLE, RD0, RD1, WR0, WR1, DONE. Request latched into internal regs at acceptance.
//  Latched: w0 = addr[31:2], w1 = w0+1, off = addr[1:0], size = 1/2/4 bytes from funct3[1:0].
//  span = (off + size > 4). Range check: w0 (and w1 if span) < MEM_WORDS.
//  Illegal funct3: loads 011/110/111; stores other than 000/001/010.
//  Error or range fail: IDLE -> DONE; resp_err=1; load_data=0; mem_re/mem_we never asserted.
//  Sequences (one state per cycle after accept):
//   aligned load / non-span load: RD0 -> DONE                (resp 2 cycles after accept)
//   span load:                    RD0 -> RD1 -> DONE         (3)
//   sw, off=0:                    WR0 -> DONE                (2)
//   sb/sh non-span, sw misaligned non-span impossible:  RD0 -> WR0 -> DONE (3)
//   span store:                   RD0 -> RD1 -> WR0 -> WR1 -> DONE (5)
//  RD0/RD1: mem_re=1, mem_addr=w0/w1; mem_rdata captured into buf0/buf1 at the edge.
//  WR0/WR1: mem_we=1, mem_addr=w0/w1, mem_wdata = low/high word of merged {buf1,buf0}.
//  Merge: 64-bit {buf1,buf0} with bytes [8*off .. 8*(off+size)-1] replaced by store data,
//   little-endian (byte k of word = bits 8k+7:8k). sw off=0 writes req_wdata directly.
//  Load extract: ({buf1,buf0} >> 8*off) truncated to size; lb/lh sign-extend, lbu/lhu zero-extend.
//  DONE: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in all states except IDLE.
//  mem_re, mem_we mutually exclusive; both 0 in IDLE and DONE; mem_addr=0 when idle.
//  Reset (async, any state): state=IDLE, resp_valid=0, resp_err=0, load_data=0, mem_re=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, buffers cleared. Request in flight is dropped, no response.
//   Span store reset in WR1: WR0 word already committed, second word not written (no rollback).
//  Back-to-back: new request may be accepted in the cycle after DONE (IDLE); no overlap.
//  req_valid low in IDLE: stay IDLE, no memory activity.
// TESTING (memory reset image: word0=0x0000000A, word7=0xA5214AAB, word8=0x00000019)
//  lb addr 28 -> resp_valid 2 cycles after accept, load_data=0xFFFFFFAB, one mem_re pulse at word 7
//  lbu addr 31 -> load_data=0x000000A5; lhu addr 29 -> 0x0000214A
//  lw addr 30 (span) -> reads word 7 then 8, resp after 3 cycles, load_data=0x0019A521
//  sb 0x5A addr 1 -> RD0,WR0 word0 written 0x00005A0A; following lw addr 0 -> 0x00005A0A
//  sw 0x11223344 addr 31 -> word7=0x44214AAB, word8=0x00112233, resp after 5 cycles, resp_err=0
//  lw addr 280 (word 70) -> resp_err=1, load_data=0, no mem_re/mem_we; rst asserted in RD1 -> IDLE, no resp

Source files
------------

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
//  Bundles the three buses of the MEM-stage load/store sequencer:
//   request  : req_valid/req_ready handshake plus store flag, funct3, byte address, store data
//   response : resp_valid pulse with resp_err and the extended load_data
//   memory   : word index, read/write enables, constant funct3, write word, read data
//  Handshake: a request transfers at a rising clk edge where req_valid & req_ready are both high.
//  The requester holds req_* stable while req_valid is high and not yet accepted. resp_valid is a
//  single-cycle pulse with no back-pressure. mem_rdata is combinational from mem_addr/mem_re, and
//  a write with mem_we high commits at the rising edge.
//  Modports:
//   master : pipeline + data memory environment (drives req_*, mem_rdata)
//   slave  : the sequencer (drives req_ready, resp_*, mem_* except mem_rdata)
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] load_data;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, load_data,
               mem_addr, mem_re, mem_we, mem_funct3, mem_wdata
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, load_data,
               mem_addr, mem_re, mem_we, mem_funct3, mem_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit
//  MEM-stage load/store sequencer. Turns byte-addressed RV32I loads/stores into full-word memory
//  cycles: read-modify-write for sb/sh, two-word split for accesses crossing a word boundary,
//  sign/zero extension of loads, and a word-range check. req_ready is low while a request is
//  in flight.
//  Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   bus        mem_access_unit_if.slave (request, response and memory buses)
//   dbg_state  current FSM state encoding (IDLE=0 RD0=1 RD1=2 WR0=3 WR1=4 DONE=5)
module mem_access_unit #(
    parameter int MEM_WORDS = 70
) (
    input  logic               clk,
    input  logic               rst,
    mem_access_unit_if.slave   bus,
    output logic [2:0]         dbg_state
);

    localparam logic [31:0] WORD_LIMIT = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t      state;

    // Request latched at acceptance
    logic [31:0] w0;
    logic [1:0]  off;
    logic [2:0]  size;
    logic        store_q;
    logic        uns_q;
    logic        span_q;
    logic [31:0] wdata_q;
    logic [31:0] buf0;
    logic [31:0] buf1;

    // Registered outputs
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] load_data_q;
    logic [31:0] mem_addr_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [31:0] mem_wdata_q;

    // Decode of the request currently presented on the bus
    logic [31:0] acc_w0;
    logic [31:0] acc_w1;
    logic [1:0]  acc_off;
    logic [2:0]  acc_size;
    logic        acc_span;
    logic        acc_illegal;
    logic        acc_bad;
    logic        acc_sw_aligned;

    always_comb begin
        acc_w0  = {2'b00, bus.req_addr[31:2]};
        acc_w1  = acc_w0 + 32'd1;
        acc_off = bus.req_addr[1:0];
        case (bus.req_funct3[1:0])
            2'b00:   acc_size = 3'd1;
            2'b01:   acc_size = 3'd2;
            default: acc_size = 3'd4;
        endcase
        acc_span = ({1'b0, acc_off} + acc_size) > 3'd4;
        if (bus.req_store) begin
            // only sb/sh/sw exist
            acc_illegal = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
        end else begin
            acc_illegal = (bus.req_funct3 == 3'b011) | (bus.req_funct3 == 3'b110) |
                          (bus.req_funct3 == 3'b111);
        end
        acc_bad = acc_illegal | (acc_w0 >= WORD_LIMIT) | (acc_span & (acc_w1 >= WORD_LIMIT));
        acc_sw_aligned = bus.req_store & (acc_off == 2'b00) & (acc_size == 3'd4);
    end

    // Merge and extract operate on the buffers as they will be after the current edge, so the
    // registered write word / load result can be loaded in the same cycle as the last read.
    logic [31:0] nxt_buf0;
    logic [31:0] nxt_buf1;
    logic [63:0] dbl;
    logic [63:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] lane_data;
    logic [63:0] merged;
    logic [63:0] shifted;
    logic [31:0] extracted;
    logic [5:0]  bit_off;

    always_comb begin
        nxt_buf0 = (state == RD0) ? bus.mem_rdata : buf0;
        nxt_buf1 = (state == RD1) ? bus.mem_rdata : buf1;
        dbl      = {nxt_buf1, nxt_buf0};
        bit_off  = {off, 3'b000};
        case (size)
            3'd1:    size_mask = 64'h0000_0000_0000_00FF;
            3'd2:    size_mask = 64'h0000_0000_0000_FFFF;
            default: size_mask = 64'h0000_0000_FFFF_FFFF;
        endcase
        lane_mask = size_mask << bit_off;
        lane_data = {32'h0, wdata_q} << bit_off;
        merged    = (dbl & ~lane_mask) | (lane_data & lane_mask);
        shifted   = dbl >> bit_off;
        case (size)
            3'd1:    extracted = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            3'd2:    extracted = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: extracted = shifted[31:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            w0           <= 32'h0;
            off          <= 2'b00;
            size         <= 3'd1;
            store_q      <= 1'b0;
            uns_q        <= 1'b0;
            span_q       <= 1'b0;
            wdata_q      <= 32'h0;
            buf0         <= 32'h0;
            buf1         <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            load_data_q  <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        w0          <= acc_w0;
                        off         <= acc_off;
                        size        <= acc_size;
                        store_q     <= bus.req_store;
                        uns_q       <= bus.req_funct3[2];
                        span_q      <= acc_span;
                        wdata_q     <= bus.req_wdata;
                        buf0        <= 32'h0;
                        buf1        <= 32'h0;
                        resp_err_q  <= 1'b0;
                        load_data_q <= 32'h0;
                        if (acc_bad) begin
                            state        <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else if (acc_sw_aligned) begin
                            // full aligned word: no read needed
                            state       <= WR0;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= acc_w0;
                            mem_wdata_q <= bus.req_wdata;
                        end else begin
                            state      <= RD0;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= acc_w0;
                        end
                    end
                end
                RD0: begin
                    buf0 <= bus.mem_rdata;
                    if (span_q) begin
                        state      <= RD1;
                        mem_addr_q <= w0 + 32'd1;
                    end else if (store_q) begin
                        state       <= WR0;
                        mem_re_q    <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merged[31:0];
                    end else begin
                        state        <= DONE;
                        mem_re_q     <= 1'b0;
                        mem_addr_q   <= 32'h0;
                        resp_valid_q <= 1'b1;
                        load_data_q  <= extracted;
                    end
                end
                RD1: begin
                    buf1 <= bus.mem_rdata;
                    mem_re_q <= 1'b0;
                    if (store_q) begin
                        state       <= WR0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= w0;
                        mem_wdata_q <= merged[31:0];
                    end else begin
                        state        <= DONE;
                        mem_addr_q   <= 32'h0;
                        resp_valid_q <= 1'b1;
                        load_data_q  <= extracted;
                    end
                end
                WR0: begin
                    if (span_q) begin
                        state       <= WR1;
                        mem_addr_q  <= w0 + 32'd1;
                        mem_wdata_q <= merged[63:32];
                    end else begin
                        state        <= DONE;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= 32'h0;
                        mem_wdata_q  <= 32'h0;
                        resp_valid_q <= 1'b1;
                    end
                end
                WR1: begin
                    state        <= DONE;
                    mem_we_q     <= 1'b0;
                    mem_addr_q   <= 32'h0;
                    mem_wdata_q  <= 32'h0;
                    resp_valid_q <= 1'b1;
                end
                DONE: begin
                    state       <= IDLE;
                    resp_err_q  <= 1'b0;
                    load_data_q <= 32'h0;
                end
                default: begin
                    state    <= IDLE;
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == IDLE) & ~rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.load_data  = load_data_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_funct3 = 3'b010;
    assign bus.mem_wdata  = mem_wdata_q;
    assign dbg_state      = state;

endmodule
